// File: rtl/acc_pkg.sv
// Shared constants and state type for the matrix accelerator core and its APB wrapper.
package acc_pkg;

  localparam int N      = 32;
  localparam int DATA_W = 8;
  localparam int ADDR_W = $clog2(N * N);
  localparam int ACC_W  = 2 * DATA_W + $clog2(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/acc_matmul_core_if.sv
// Operand/result buffer ports and start/busy/done control between the wrapper and the core.
interface acc_matmul_core_if
  import acc_pkg::*;
#(
  parameter int N      = acc_pkg::N,
  parameter int DATA_W = acc_pkg::DATA_W
);

  localparam int ADDR_W = $clog2(N * N);

  logic              start;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] a_raddr;
  logic [DATA_W-1:0] a_rdata;
  logic [ADDR_W-1:0] b_raddr;
  logic [DATA_W-1:0] b_rdata;
  logic              c_we;
  logic [ADDR_W-1:0] c_waddr;
  logic [DATA_W-1:0] c_wdata;

  // Wrapper side: owns the buffers and the start bit.
  modport master (
    output start, a_rdata, b_rdata,
    input  busy, done, a_raddr, b_raddr, c_we, c_waddr, c_wdata
  );

  // Core side.
  modport slave (
    input  start, a_rdata, b_rdata,
    output busy, done, a_raddr, b_raddr, c_we, c_waddr, c_wdata
  );

endinterface

// File: rtl/acc_mac_unit.sv
// Registered unsigned multiply-accumulate with synchronous clear. The saturated
// output is taken from the value being loaded this cycle so the caller can
// register the final byte in the same edge that completes the sum.
module acc_mac_unit
  import acc_pkg::*;
#(
  parameter int DATA_W = acc_pkg::DATA_W,
  parameter int ACC_W  = acc_pkg::ACC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] sat_o
);

  localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** DATA_W) - 1);

  logic [ACC_W-1:0]    acc_q;
  logic [ACC_W-1:0]    acc_d;
  logic [2*DATA_W-1:0] prod_s;

  // Clamp an accumulator value to the element range.
  function automatic logic [DATA_W-1:0] sat_fn(input logic [ACC_W-1:0] v);
    if (v > SAT_MAX) begin
      return {DATA_W{1'b1}};
    end else begin
      return v[DATA_W-1:0];
    end
  endfunction

  // Next accumulator value: clear wins over accumulate.
  always_comb begin
    prod_s = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
    acc_d  = acc_q;
    if (clr) begin
      acc_d = {ACC_W{1'b0}};
    end else if (en) begin
      acc_d = acc_q + ACC_W'(prod_s);
    end else begin
      acc_d = acc_q;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= {ACC_W{1'b0}};
    end else begin
      acc_q <= acc_d;
    end
  end

  // Saturated view of the value being accumulated this cycle.
  always_comb begin
    sat_o = sat_fn(acc_d);
  end

endmodule

// File: rtl/acc_matmul_core.sv
// Matrix multiply engine: C = A*B over N x N unsigned bytes, one operand pair per
// cycle through synchronous-read buffers, saturated result bytes written back.
module acc_matmul_core
  import acc_pkg::*;
#(
  parameter int N      = acc_pkg::N,
  parameter int DATA_W = acc_pkg::DATA_W
) (
  input logic              HCLK,
  input logic              HRESETn,
  acc_matmul_core_if.slave bus
);

  localparam int ADDR_W = $clog2(N * N);
  localparam int ACC_W  = 2 * DATA_W + $clog2(N);
  localparam int CNT_W  = $clog2(N);
  localparam int OFF_W  = $clog2(N + 2);

  // Offset landmarks inside one element's N+2 cycle slot.
  localparam logic [OFF_W-1:0] OFF_ZERO     = {OFF_W{1'b0}};
  localparam logic [OFF_W-1:0] OFF_ONE      = OFF_W'(1);
  localparam logic [OFF_W-1:0] OFF_LAST_PRE = OFF_W'(N - 2);  // last offset that prefetches k+1
  localparam logic [OFF_W-1:0] OFF_LAST_MAC = OFF_W'(N);
  localparam logic [OFF_W-1:0] OFF_WRITE    = OFF_W'(N + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(N - 1);

  state_e            state_q, state_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic [CNT_W-1:0]  i_q, i_d;
  logic [CNT_W-1:0]  j_q, j_d;
  logic              hist_q, hist_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              c_we_q, c_we_d;
  logic [ADDR_W-1:0] c_waddr_q, c_waddr_d;
  logic [DATA_W-1:0] c_wdata_q, c_wdata_d;
  logic [ADDR_W-1:0] a_raddr_q, a_raddr_d;
  logic [ADDR_W-1:0] b_raddr_q, b_raddr_d;
  logic              mac_clr_s;
  logic              mac_en_s;
  logic [DATA_W-1:0] mac_sat_s;

  // Row-major byte address of (row, col).
  function automatic logic [ADDR_W-1:0] addr_of(input logic [CNT_W-1:0] row,
                                                 input logic [CNT_W-1:0] col);
    return ADDR_W'(row) * ADDR_W'(N) + ADDR_W'(col);
  endfunction

  acc_mac_unit #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk   (HCLK),
    .rst_n (HRESETn),
    .clr   (mac_clr_s),
    .en    (mac_en_s),
    .a     (bus.a_rdata),
    .b     (bus.b_rdata),
    .sat_o (mac_sat_s)
  );

  // Sequencer: start-edge detect, element/offset counters, address generation, write-back.
  always_comb begin
    state_d   = state_q;
    off_d     = off_q;
    i_d       = i_q;
    j_d       = j_q;
    hist_d    = hist_q;
    busy_d    = busy_q;
    done_d    = done_q;
    c_we_d    = 1'b0;
    c_waddr_d = c_waddr_q;
    c_wdata_d = c_wdata_q;
    a_raddr_d = a_raddr_q;
    b_raddr_d = b_raddr_q;
    mac_clr_s = 1'b0;
    mac_en_s  = 1'b0;
    case (state_q)
      IDLE: begin
        // History only tracks start while idle, so toggles during a run are invisible.
        hist_d = bus.start;
        if (bus.start && !hist_q) begin
          state_d   = RUN;
          off_d     = OFF_ZERO;
          i_d       = CNT_ZERO;
          j_d       = CNT_ZERO;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          a_raddr_d = addr_of(CNT_ZERO, CNT_ZERO);
          b_raddr_d = addr_of(CNT_ZERO, CNT_ZERO);
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        mac_clr_s = (off_q == OFF_ZERO);
        mac_en_s  = (off_q >= OFF_ONE) && (off_q <= OFF_LAST_MAC);
        if (off_q == OFF_WRITE) begin
          off_d = OFF_ZERO;
          if (j_q == CNT_LAST) begin
            j_d = CNT_ZERO;
            if (i_q == CNT_LAST) begin
              i_d     = CNT_ZERO;
              state_d = DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              i_d = i_q + CNT_ONE;
            end
          end else begin
            j_d = j_q + CNT_ONE;
          end
          a_raddr_d = addr_of(i_d, CNT_ZERO);
          b_raddr_d = addr_of(CNT_ZERO, j_d);
        end else begin
          off_d = off_q + OFF_ONE;
          if (off_q == OFF_LAST_MAC) begin
            // Last product lands this edge: register the finished byte.
            c_we_d    = 1'b1;
            c_waddr_d = addr_of(i_q, j_q);
            c_wdata_d = mac_sat_s;
          end else if (off_q <= OFF_LAST_PRE) begin
            a_raddr_d = addr_of(i_q, CNT_W'(off_d));
            b_raddr_d = addr_of(CNT_W'(off_d), j_q);
          end else begin
            a_raddr_d = a_raddr_q;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= IDLE;
      off_q     <= OFF_ZERO;
      i_q       <= CNT_ZERO;
      j_q       <= CNT_ZERO;
      hist_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      c_we_q    <= 1'b0;
      c_waddr_q <= {ADDR_W{1'b0}};
      c_wdata_q <= {DATA_W{1'b0}};
      a_raddr_q <= {ADDR_W{1'b0}};
      b_raddr_q <= {ADDR_W{1'b0}};
    end else begin
      state_q   <= state_d;
      off_q     <= off_d;
      i_q       <= i_d;
      j_q       <= j_d;
      hist_q    <= hist_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      c_we_q    <= c_we_d;
      c_waddr_q <= c_waddr_d;
      c_wdata_q <= c_wdata_d;
      a_raddr_q <= a_raddr_d;
      b_raddr_q <= b_raddr_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.c_we    = c_we_q;
  assign bus.c_waddr = c_waddr_q;
  assign bus.c_wdata = c_wdata_q;
  assign bus.a_raddr = a_raddr_q;
  assign bus.b_raddr = b_raddr_q;

endmodule

// File: tb/tb_acc_matmul_core.sv
// Self-checking bench for acc_matmul_core at a reduced matrix size.
module tb_acc_matmul_core;

  localparam int N        = 8;
  localparam int NN       = N * N;
  localparam int RUN_CYC  = NN * (N + 2);
  localparam int DONE_CYC = 1 + RUN_CYC;

  localparam int K_ZERO  = 0;
  localparam int K_IDENT = 1;
  localparam int K_RAMP  = 2;
  localparam int K_FF    = 3;
  localparam int K_ONE   = 4;
  localparam int K_RND   = 5;
  localparam int K_RNDS  = 6;

  typedef struct {
    int a_kind;
    int a_val;
    int b_kind;
    int b_val;
    int exp_c0;   // -1: only the model decides
    int exp_nz;   // nonzero result bytes, -1: only the model decides
  } vec_t;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  int   nchk = 0;
  int   nerr = 0;

  logic [7:0] mem_a [NN];
  logic [7:0] mem_b [NN];
  int         exp_c [NN];
  vec_t       vecs  [7];

  always #5 HCLK = ~HCLK;

  acc_matmul_core_if #(.N(N), .DATA_W(8)) bus();

  acc_matmul_core #(.N(N), .DATA_W(8)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  // Synchronous-read operand buffers.
  always @(posedge HCLK) begin
    bus.a_rdata <= mem_a[bus.a_raddr];
    bus.b_rdata <= mem_b[bus.b_raddr];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] gen(input int kind, input int val, input int idx);
    case (kind)
      K_ZERO:  return 8'd0;
      K_IDENT: return (idx / N == idx % N) ? 8'd1 : 8'd0;
      K_RAMP:  return 8'(idx % 256);
      K_FF:    return 8'hFF;
      K_ONE:   return (idx == 0) ? 8'(val) : 8'd0;
      K_RND:   return 8'($urandom);
      default: return 8'($urandom_range(0, 15));
    endcase
  endfunction

  // Reference: plain matrix product, clamped to a byte.
  task automatic build_model();
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        longint s = 0;
        for (int k = 0; k < N; k++) s += int'(mem_a[i*N+k]) * int'(mem_b[k*N+j]);
        exp_c[i*N+j] = (s > 255) ? 255 : int'(s);
      end
    end
  endtask

  task automatic fill(input vec_t v);
    for (int x = 0; x < NN; x++) begin
      mem_a[x] = gen(v.a_kind, v.a_val, x);
      mem_b[x] = gen(v.b_kind, v.b_val, x);
    end
    build_model();
  endtask

  // One full run from a start rise; optionally toggles start low/high mid-run.
  task automatic run_check(input string nm, input int lo_at, input int hi_at,
                           output int c0, output int nz);
    int c, nw, bad_prof, done_cyc, expv;
    nw = 0; bad_prof = 0; done_cyc = -1; c0 = -1; nz = 0;
    @(negedge HCLK);
    bus.start = 1'b1;
    c = 0;
    while (done_cyc < 0 && c < DONE_CYC + 40) begin
      @(negedge HCLK);
      c++;
      if (c == lo_at) bus.start = 1'b0;
      if (c == hi_at) bus.start = 1'b1;
      if (bus.busy !== (c <= RUN_CYC)) bad_prof++;
      if (bus.done !== (c >= DONE_CYC)) bad_prof++;
      if (bus.c_we === 1'b1) begin
        expv = (nw < NN) ? exp_c[nw] : 999;
        chk({nm, "_waddr"}, 64'(bus.c_waddr), 64'(nw));
        chk({nm, "_wdata"}, 64'(bus.c_wdata), 64'(expv));
        chk({nm, "_wcycle"}, 64'(c), 64'((nw + 1) * (N + 2)));
        if (nw == 0) c0 = int'(bus.c_wdata);
        if (bus.c_wdata != 8'd0) nz++;
        nw++;
      end
      if (bus.done === 1'b1) done_cyc = c;
    end
    chk({nm, "_done_cycle"}, 64'(done_cyc), 64'(DONE_CYC));
    chk({nm, "_writes"}, 64'(nw), 64'(NN));
    chk({nm, "_busy_done_profile"}, 64'(bad_prof), 64'd0);
  endtask

  task automatic settle_low();
    bus.start = 1'b0;
    repeat (3) @(negedge HCLK);
  endtask

  initial begin
    int c0, nz, cnt;
    vecs[0] = '{K_IDENT, 0, K_RAMP,  0, 0,   63};
    vecs[1] = '{K_FF,    0, K_FF,    0, 255, 64};
    vecs[2] = '{K_ONE,   2, K_ONE,   3, 6,   1};
    vecs[3] = '{K_RAMP,  0, K_IDENT, 0, 0,   63};
    vecs[4] = '{K_RND,   0, K_RND,   0, -1,  -1};
    vecs[5] = '{K_RNDS,  0, K_RNDS,  0, -1,  -1};
    vecs[6] = '{K_ZERO,  0, K_FF,    0, 0,   0};

    bus.start = 1'b0;
    for (int x = 0; x < NN; x++) begin
      mem_a[x] = 8'd0;
      mem_b[x] = 8'd0;
    end
    repeat (3) @(negedge HCLK);
    chk("reset_outputs_in_reset", 64'({bus.busy, bus.done, bus.c_we, bus.a_raddr,
        bus.b_raddr, bus.c_waddr, bus.c_wdata}), 64'd0);
    HRESETn = 1'b1;
    repeat (2) @(negedge HCLK);
    chk("idle_after_reset", 64'({bus.busy, bus.done, bus.c_we, bus.a_raddr,
        bus.b_raddr, bus.c_waddr, bus.c_wdata}), 64'd0);

    // Table-driven runs.
    for (int v = 0; v < 7; v++) begin
      fill(vecs[v]);
      run_check($sformatf("vec%0d", v), -1, -1, c0, nz);
      if (vecs[v].exp_c0 >= 0) chk($sformatf("vec%0d_c0", v), 64'(c0), 64'(vecs[v].exp_c0));
      if (vecs[v].exp_nz >= 0) chk($sformatf("vec%0d_nonzero", v), 64'(nz), 64'(vecs[v].exp_nz));
      settle_low();
    end

    // Start toggled low then high mid-run: ignored, timing unchanged.
    fill('{K_RND, 0, K_RND, 0, -1, -1});
    run_check("ignored_edge", 100, 300, c0, nz);
    // start is still high: no rerun, done stays.
    cnt = 0;
    repeat (30) begin
      @(negedge HCLK);
      if (bus.busy !== 1'b0 || bus.c_we !== 1'b0 || bus.done !== 1'b1) cnt++;
    end
    chk("held_high_no_rerun", 64'(cnt), 64'd0);
    settle_low();
    chk("done_holds_after_start_low", 64'(bus.done), 64'd1);
    run_check("rerun_after_toggle", -1, -1, c0, nz);
    settle_low();

    // Reset in the middle of a run.
    fill('{K_RND, 0, K_RNDS, 0, -1, -1});
    @(negedge HCLK);
    bus.start = 1'b1;
    repeat (300) @(negedge HCLK);
    chk("busy_mid_run", 64'(bus.busy), 64'd1);
    #1 HRESETn = 1'b0;
    #1 chk("reset_mid_run_outputs", 64'({bus.busy, bus.done, bus.c_we, bus.a_raddr,
           bus.b_raddr, bus.c_waddr, bus.c_wdata}), 64'd0);
    bus.start = 1'b0;
    @(negedge HCLK);
    HRESETn = 1'b1;
    cnt = 0;
    repeat (20) begin
      @(negedge HCLK);
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.c_we !== 1'b0) cnt++;
    end
    chk("idle_after_mid_run_reset", 64'(cnt), 64'd0);
    run_check("run_after_reset", -1, -1, c0, nz);

    // start still high across a reset release counts as a fresh edge.
    @(negedge HCLK);
    HRESETn = 1'b0;
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(negedge HCLK);
    chk("start_high_through_reset", 64'({bus.busy, bus.done}), 64'b10);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
